// File: rtl/median_window_ctrl_pkg.sv
// median_pkg: shared state type, pixel width and frame/window defaults for the median preparation path
package median_pkg;
  localparam int PIX_W = 8;
  localparam int DEF_IMG_WIDTH = 17;
  localparam int DEF_IMG_HEIGHT = 17;
  localparam int DEF_WIN = 17;
  localparam int DEF_LAT = 8;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_e;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/median_window_ctrl_if.sv
// median_window_ctrl_if: pixel stream in, line-buffer feed plus window/frame status out
interface median_window_ctrl_if
  import median_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
);
  logic                      done_i;
  logic [PIX_W-1:0]          data_i;
  logic                      buf_en_o;
  logic [PIX_W-1:0]          buf_data_o;
  logic                      win_valid_o;
  logic [cw(IMG_HEIGHT)-1:0] win_row_o;
  logic [cw(IMG_WIDTH)-1:0]  win_col_o;
  logic                      busy_o;
  logic                      frame_done_o;
  logic                      err_o;
  modport master(
    output done_i, data_i,
    input  buf_en_o, buf_data_o, win_valid_o, win_row_o, win_col_o, busy_o, frame_done_o, err_o
  );
  modport slave(
    input  done_i, data_i,
    output buf_en_o, buf_data_o, win_valid_o, win_row_o, win_col_o, busy_o, frame_done_o, err_o
  );
endinterface

// File: rtl/median_window_ctrl_raster_counter.sv
// raster_counter: raster position of accepted pixels, with frame-end and window-region flags
module raster_counter
  import median_pkg::*;
#(
  parameter  int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter  int WIN = DEF_WIN,
  localparam int CW = cw(IMG_WIDTH),
  localparam int RW = cw(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last,
  output logic          o_in_win,
  output logic          o_fill_done
);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_end;
  assign w_col_end   = int'(r_col) == IMG_WIDTH - 1;
  assign o_last      = w_col_end && int'(r_row) == IMG_HEIGHT - 1;
  assign o_fill_done = int'(r_row) >= WIN - 1;
  assign o_in_win    = o_fill_done && int'(r_col) >= WIN - 1;
  assign o_col       = r_col;
  assign o_row       = r_row;
  // the last pixel returns both counters to the origin so the next frame starts at (0,0)
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      r_col <= w_col_end ? '0 : r_col + CW'(1);
      r_row <= o_last ? '0 : w_col_end ? r_row + RW'(1) : r_row;
    end
endmodule

// File: rtl/median_window_ctrl.sv
// median_window_ctrl: feeds the line buffer, flags complete windows with their centre,
// and drains the sorter latency before pulsing end of frame
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int WIN = DEF_WIN,
  parameter int LAT = DEF_LAT
) (
  input logic                 clk,
  input logic                 rst,
  median_window_ctrl_if.slave bus
);
  localparam int CW = cw(IMG_WIDTH);
  localparam int RW = cw(IMG_HEIGHT);
  localparam int DW = cw(LAT + 1);
  localparam int HALF = (WIN - 1) / 2;
  state_e           r_state, w_next;
  logic [DW-1:0]    r_drain;
  logic [CW-1:0]    w_col, r_win_col;
  logic [RW-1:0]    w_row, r_win_row;
  logic [PIX_W-1:0] r_buf_data;
  logic             w_accept, w_last, w_in_win, w_fill_done, w_drain_end, w_win;
  logic             r_buf_en, r_win_valid, r_busy, r_frame_done, r_err;
  assign w_accept    = bus.done_i && r_state != DRAIN;
  assign w_win       = w_accept && w_in_win;
  assign w_drain_end = r_state == DRAIN && int'(r_drain) == LAT - 1;
  raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .WIN       (WIN)
  ) u_raster (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_accept),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_last     (w_last),
    .o_in_win   (w_in_win),
    .o_fill_done(w_fill_done)
  );
  // the last pixel wins over every other transition, so tiny frames still reach DRAIN
  always_comb
    w_next = (w_accept && w_last)              ? DRAIN :
             (r_state == IDLE && w_accept)     ? FILL  :
             (r_state == FILL && w_fill_done)  ? RUN   :
             w_drain_end                       ? IDLE  : r_state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state      <= IDLE;
      r_drain      <= '0;
      r_buf_en     <= 1'b0;
      r_buf_data   <= '0;
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_drain      <= (r_state == DRAIN) ? r_drain + DW'(1) : '0;
      r_buf_en     <= w_accept;
      if (w_accept) r_buf_data <= bus.data_i;
      r_win_valid  <= w_win;
      if (w_win) begin
        r_win_row <= RW'(int'(w_row) - HALF);
        r_win_col <= CW'(int'(w_col) - HALF);
      end
      r_busy       <= w_next != IDLE;
      r_frame_done <= w_drain_end;
      r_err        <= r_err || (r_state == DRAIN && bus.done_i);
    end
  assign bus.buf_en_o     = r_buf_en;
  assign bus.buf_data_o   = r_buf_data;
  assign bus.win_valid_o  = r_win_valid;
  assign bus.win_row_o    = r_win_row;
  assign bus.win_col_o    = r_win_col;
  assign bus.busy_o       = r_busy;
  assign bus.frame_done_o = r_frame_done;
  assign bus.err_o        = r_err;
endmodule

// File: tb/tb_median_window_ctrl.sv
// tb_median_window_ctrl: scoreboard bench for the line-buffer sequencer at 17x17 and 20x20, WIN=17
module tb_median_window_ctrl;
  import median_pkg::*;
  localparam int LAT = 8;
  typedef struct {
    logic [7:0] d;
    bit         w;
    int         r;
    int         c;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0, n_checks = 0, n_fail = 0;
  int   a_en = 0, a_win = 0, a_fd = 0, a_last = 0;
  int   b_en = 0, b_win = 0, b_fd = 0, b_last = 0;
  logic a_dsmp = 1'b0, b_dsmp = 1'b0;
  exp_t qa[$], qb[$];
  median_window_ctrl_if #(.IMG_WIDTH(17), .IMG_HEIGHT(17)) a ();
  median_window_ctrl_if #(.IMG_WIDTH(20), .IMG_HEIGHT(20)) b ();
  median_window_ctrl #(.IMG_WIDTH(17), .IMG_HEIGHT(17), .WIN(17), .LAT(LAT)) u_a (.clk(clk), .rst(rst), .bus(a));
  median_window_ctrl #(.IMG_WIDTH(20), .IMG_HEIGHT(20), .WIN(17), .LAT(LAT)) u_b (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    a_dsmp <= a.done_i;
    b_dsmp <= b.done_i;
  end
  task automatic chk(input string n, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", n, act, exp, $time);
    end
  endtask
  function automatic exp_t mk(input int p, input int w);
    exp_t e;
    int r, c;
    r = (p - 1) / w;
    c = (p - 1) % w;
    e.d = 8'(p);
    e.w = r >= 16 && c >= 16;
    e.r = r - 8;
    e.c = c - 8;
    return e;
  endfunction
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst && a.buf_en_o) begin
      a_en++;
      a_last = cyc;
      chk("a_en_follows_done", int'(a_dsmp), 1);
      chk("a_expected_pending", int'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_buf_data", int'(a.buf_data_o), int'(e.d));
        chk("a_win_valid", int'(a.win_valid_o), int'(e.w));
        if (e.w) begin
          chk("a_win_row", int'(a.win_row_o), e.r);
          chk("a_win_col", int'(a.win_col_o), e.c);
        end
      end
    end else if (rst && a.win_valid_o) chk("a_win_without_en", int'(a.win_valid_o), 0);
    if (a.win_valid_o) a_win++;
    if (a.frame_done_o) begin
      a_fd++;
      chk("a_frame_done_latency", cyc - a_last, LAT);
    end
  end
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst && b.buf_en_o) begin
      b_en++;
      b_last = cyc;
      chk("b_en_follows_done", int'(b_dsmp), 1);
      chk("b_expected_pending", int'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_buf_data", int'(b.buf_data_o), int'(e.d));
        chk("b_win_valid", int'(b.win_valid_o), int'(e.w));
        if (e.w) begin
          chk("b_win_row", int'(b.win_row_o), e.r);
          chk("b_win_col", int'(b.win_col_o), e.c);
        end
      end
    end
    if (b.win_valid_o) b_win++;
    if (b.frame_done_o) begin
      b_fd++;
      chk("b_frame_done_latency", cyc - b_last, LAT);
    end
  end
  task automatic frame_a(input int npix, input bit gaps);
    for (int p = 1; p <= npix; p++) begin
      @(posedge clk);
      #1;
      if (p == 1) begin
        a_en = 0;
        a_win = 0;
        a_fd = 0;
      end
      if (p == 290) chk("a_err_before_drain_px", int'(a.err_o), 0);
      if (p == 291) chk("a_err_after_drain_px", int'(a.err_o), 1);
      a.done_i = 1'b1;
      a.data_i = 8'(p);
      if (p <= 289) qa.push_back(mk(p, 17));
      if (gaps) begin
        @(posedge clk);
        #1;
        a.done_i = 1'b0;
        a.data_i = 8'hA5;
      end
    end
    @(posedge clk);
    #1;
    a.done_i = 1'b0;
  endtask
  task automatic end_a(input int exp_err);
    int n = 0;
    while (!a.frame_done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_frame_done_seen", int'(a.frame_done_o), 1);
    chk("a_busy_at_done", int'(a.busy_o), 0);
    chk("a_accepts", a_en, 289);
    chk("a_windows", a_win, 1);
    chk("a_err", int'(a.err_o), exp_err);
    chk("a_queue_drained", qa.size(), 0);
  endtask
  task automatic zero_a(input string tag);
    chk({tag, "_buf_en"}, int'(a.buf_en_o), 0);
    chk({tag, "_buf_data"}, int'(a.buf_data_o), 0);
    chk({tag, "_win_valid"}, int'(a.win_valid_o), 0);
    chk({tag, "_win_row"}, int'(a.win_row_o), 0);
    chk({tag, "_win_col"}, int'(a.win_col_o), 0);
    chk({tag, "_busy"}, int'(a.busy_o), 0);
    chk({tag, "_frame_done"}, int'(a.frame_done_o), 0);
    chk({tag, "_err"}, int'(a.err_o), 0);
  endtask
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end
  initial begin
    int n;
    a.done_i = 1'b0;
    a.data_i = '0;
    b.done_i = 1'b0;
    b.data_i = '0;
    #1 rst = 1'b0;
    #2;
    zero_a("rst");
    chk("rst_b_busy", int'(b.busy_o), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int p = 1; p <= 400; p++) begin
      @(posedge clk);
      #1;
      b.done_i = 1'b1;
      b.data_i = 8'(p);
      qb.push_back(mk(p, 20));
    end
    @(posedge clk);
    #1 b.done_i = 1'b0;
    n = 0;
    while (!b.frame_done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_frame_done_seen", int'(b.frame_done_o), 1);
    chk("b_accepts", b_en, 400);
    chk("b_windows", b_win, 16);
    chk("b_queue_drained", qb.size(), 0);
    repeat (3) @(negedge clk);
    chk("b_frame_done_pulses", b_fd, 1);
    frame_a(150, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_queue_drained", qa.size(), 0);
    chk("mid_busy", int'(a.busy_o), 1);
    rst = 1'b0;
    #1;
    zero_a("midrst");
    @(posedge clk);
    #1 rst = 1'b1;
    frame_a(289, 1'b0);
    end_a(0);
    frame_a(289, 1'b0);
    end_a(0);
    repeat (3) @(negedge clk);
    chk("a_b2b_frame_done_pulses", a_fd, 1);
    frame_a(289, 1'b1);
    end_a(0);
    repeat (3) @(negedge clk);
    chk("a_gap_frame_done_pulses", a_fd, 1);
    frame_a(295, 1'b0);
    end_a(1);
    repeat (20) @(negedge clk);
    chk("a_overrun_frame_done_pulses", a_fd, 1);
    chk("a_err_sticky", int'(a.err_o), 1);
    chk("a_overrun_accepts", a_en, 289);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
